// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Width of the chunk counter; a single-chunk adder still needs one bit.
    function automatic int cnt_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder slice with carry-into-MSB tap.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a registered carry,
// valid/ready handshake on both sides, all outputs registered.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_w(NCHUNK);

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry, sub_q, cout_q, ovf_q, in_ready_q, out_valid_q;

    logic [CHUNK-1:0] a_k, b_k, s_k;
    logic             c_out, c_msb;

    assign a_k = a_q[int'(cnt)*CHUNK +: CHUNK];
    assign b_k = b_q[int'(cnt)*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .sum  (s_k),
        .cout (c_out),
        .cmsb (c_msb),
        .a    (a_k),
        .b    (b_k),
        .cin  (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            sub_q       <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Subtraction is A + ~B + ~borrow, so the datapath only ever adds.
                    a_q        <= a;
                    b_q        <= sub ? ~b : b;
                    carry      <= sub ? ~cin : cin;
                    sub_q      <= sub;
                    cnt        <= '0;
                    in_ready_q <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    sum_q[int'(cnt)*CHUNK +: CHUNK] <= s_k;
                    carry <= c_out;
                    if (cnt == CW'(NCHUNK - 1)) begin
                        cout_q      <= sub_q ? ~c_out : c_out;
                        ovf_q       <= c_msb ^ c_out;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: five WIDTH/CHUNK configurations against an arithmetic model.
module tb_seq_chunk_adder;

    localparam int NCFG = 5;
    localparam int WS [NCFG] = '{8, 8, 32, 32, 64};
    localparam int CS [NCFG] = '{8, 4, 4, 1, 16};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid [NCFG];
    logic        out_ready[NCFG];
    logic        cin      [NCFG];
    logic        sub      [NCFG];
    logic [63:0] a        [NCFG];
    logic [63:0] b        [NCFG];
    logic        in_ready [NCFG];
    logic        out_valid[NCFG];
    logic        cout     [NCFG];
    logic        ovf      [NCFG];
    logic [63:0] sum      [NCFG];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W = WS[g];
        localparam int C = CS[g];
        logic [W-1:0] s;
        logic         ir, ov, co, of;

        seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (ir),
            .a         (a[g][W-1:0]),
            .b         (b[g][W-1:0]),
            .cin       (cin[g]),
            .sub       (sub[g]),
            .out_valid (ov),
            .out_ready (out_ready[g]),
            .sum       (s),
            .cout      (co),
            .ovf       (of)
        );

        assign sum[g]       = 64'(s);
        assign in_ready[g]  = ir;
        assign out_valid[g] = ov;
        assign cout[g]      = co;
        assign ovf[g]       = of;
    end

    // Reference: exact integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [65:0] model(input int w, input logic [63:0] av, bv,
                                          input logic ci, sb);
        logic [63:0]        mask, am, bm;
        logic [64:0]        r;
        logic signed [66:0] one, sa, sbv, cs, t, hi, lo;
        logic               co, of;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = av & mask;
        bm   = bv & mask;
        r    = sb ? ({1'b0, am} - {1'b0, bm} - 65'(ci)) : ({1'b0, am} + {1'b0, bm} + 65'(ci));
        co   = r[w];
        one  = 67'sd1;
        sa   = signed'({3'b0, am});
        sbv  = signed'({3'b0, bm});
        if (am[w-1]) sa  = sa - (one <<< w);
        if (bm[w-1]) sbv = sbv - (one <<< w);
        cs   = ci ? one : 67'sd0;
        t    = sb ? (sa - sbv - cs) : (sa + sbv + cs);
        hi   = (one <<< (w - 1)) - one;
        lo   = -(one <<< (w - 1));
        of   = (t > hi) || (t < lo);
        return {of, co, r[63:0] & mask};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on config g; stall = cycles out_ready stays low once valid.
    task automatic do_op(input int g, input logic [63:0] av, bv, input logic ci, sb,
                         input int stall);
        int          nch;
        int          t;
        logic [65:0] e;
        string       id;
        nch = WS[g] / CS[g];
        e   = model(WS[g], av, bv, ci, sb);
        id  = $sformatf("cfg%0d a=%0h b=%0h c=%0b s=%0b", g, av, bv, ci, sb);
        t = 0;
        while (!in_ready[g] && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 200) chk({id, " ready_timeout"}, 64'(in_ready[g]), 64'd1);
        @(negedge clk);
        a[g] = av; b[g] = bv; cin[g] = ci; sub[g] = sb;
        in_valid[g]  = 1'b1;
        out_ready[g] = (stall == 0);
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
        // scramble the input bus: the block must work from latched operands
        a[g] = {$urandom, $urandom}; b[g] = {$urandom, $urandom};
        cin[g] = 1'($urandom); sub[g] = 1'($urandom);
        chk({id, " in_ready_busy"}, 64'(in_ready[g]), 64'd0);
        repeat (nch - 1) @(posedge clk);
        #1 chk({id, " valid_early"}, 64'(out_valid[g]), 64'd0);
        @(posedge clk); #1;
        chk({id, " valid"}, 64'(out_valid[g]), 64'd1);
        chk({id, " sum"},   sum[g], e[63:0]);
        chk({id, " cout"},  64'(cout[g]), 64'(e[64]));
        chk({id, " ovf"},   64'(ovf[g]),  64'(e[65]));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({id, " stall_valid"}, 64'(out_valid[g]), 64'd1);
            chk({id, " stall_ready"}, 64'(in_ready[g]),  64'd0);
            chk({id, " stall_sum"},   sum[g], e[63:0]);
            chk({id, " stall_flags"}, {62'd0, ovf[g], cout[g]}, {62'd0, e[65:64]});
        end
        if (stall > 0) begin
            @(negedge clk);
            out_ready[g] = 1'b1;
        end
        @(posedge clk); #1;
        chk({id, " consumed"},  64'(out_valid[g]), 64'd0);
        chk({id, " ready_again"}, 64'(in_ready[g]), 64'd1);
        @(negedge clk);
        out_ready[g] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            in_valid[g] = 1'b0; out_ready[g] = 1'b0; cin[g] = 1'b0; sub[g] = 1'b0;
            a[g] = '0; b[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("cfg%0d reset_ready", g), 64'(in_ready[g]), 64'd1);
            chk($sformatf("cfg%0d reset_valid", g), 64'(out_valid[g]), 64'd0);
            chk($sformatf("cfg%0d reset_sum", g),   sum[g], 64'd0);
            chk($sformatf("cfg%0d reset_flags", g), {62'd0, ovf[g], cout[g]}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // directed, WIDTH=8 CHUNK=4
        do_op(1, 64'h3C, 64'h05, 1'b0, 1'b0, 0);
        do_op(1, 64'h7F, 64'h01, 1'b0, 1'b0, 1);
        do_op(1, 64'hFF, 64'h01, 1'b0, 1'b0, 0);
        do_op(1, 64'h10, 64'h20, 1'b0, 1'b1, 2);
        do_op(1, 64'h80, 64'h01, 1'b0, 1'b1, 0);
        do_op(1, 64'h00, 64'h00, 1'b1, 1'b1, 0);
        do_op(0, 64'hFF, 64'hFF, 1'b1, 1'b0, 0);

        // backpressure, WIDTH=32 CHUNK=4
        do_op(2, 64'h1234_5678, 64'h8765_4321, 1'b1, 1'b0, 20);

        // reset while the third chunk is being added
        @(negedge clk);
        a[2] = 64'h1234_5678; b[2] = 64'h1111_1111; cin[2] = 1'b0; sub[2] = 1'b0;
        in_valid[2] = 1'b1;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_ready", 64'(in_ready[2]), 64'd1);
        chk("midrun_reset_valid", 64'(out_valid[2]), 64'd0);
        chk("midrun_reset_sum",   sum[2], 64'd0);
        chk("midrun_reset_flags", {62'd0, ovf[2], cout[2]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
        chk("wrap_sum_const", sum[2], 64'd0);

        // random regression over every configuration
        for (int g = 0; g < NCFG; g++) begin
            for (int n = 0; n < 40; n++) begin
                logic [63:0] ra, rb;
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) rb = ~ra;
                do_op(g, ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
